// File: rtl/pwr_seq_ctrl.sv
// pwr_seq_ctrl: power-sequencing controller for one switchable domain (clock gate, isolation, retention, switch, reset)
module pwr_seq_ctrl #(
    parameter int ISO_DLY    = 2,
    parameter int RST_DLY    = 2,
    parameter int SW_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pd_req,
    input  logic       pu_req,
    input  logic       pwr_ack,
    output logic       pwr_on,
    output logic       clk_en,
    output logic       iso_en,
    output logic       save,
    output logic       restore,
    output logic       dom_rst_n,
    output logic       busy,
    output logic       err_timeout,
    output logic [3:0] state_o
);
    typedef enum logic [3:0] {
        OFF      = 4'd0,
        PSW_ON   = 4'd1,
        RESTORE  = 4'd2,
        RST_HOLD = 4'd3,
        ISO_OFF  = 4'd4,
        ON       = 4'd5,
        CG_OFF   = 4'd6,
        ISO_ON   = 4'd7,
        SAVE     = 4'd8,
        PSW_OFF  = 4'd9
    } state_t;

    localparam int CW = $clog2(SW_TIMEOUT + ISO_DLY + RST_DLY + 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          ret_valid, ret_n, err_n;
    logic          pwr_on_nx, clk_en_nx, iso_en_nx, save_nx, restore_nx, dom_rst_n_nx, busy_nx;

    always_comb begin
        state_n = state;
        ret_n   = ret_valid;
        err_n   = err_timeout;
        case (state)
            ON:       if (pd_req) state_n = CG_OFF;
            CG_OFF:   state_n = ISO_ON;
            ISO_ON:   if (cnt == CW'(ISO_DLY - 1)) state_n = SAVE;
            SAVE: begin
                state_n = PSW_OFF;
                ret_n   = 1'b1;
            end
            PSW_OFF: begin
                if (!pwr_ack) state_n = OFF;
                else if (cnt == CW'(SW_TIMEOUT - 1)) begin
                    state_n = OFF;
                    err_n   = 1'b1;
                end
            end
            OFF:      if (pu_req) state_n = PSW_ON;
            PSW_ON: begin
                // an ack on the final wait cycle takes priority over the timeout
                if (pwr_ack) state_n = ret_valid ? RESTORE : RST_HOLD;
                else if (cnt == CW'(SW_TIMEOUT - 1)) begin
                    state_n = OFF;
                    err_n   = 1'b1;
                end
            end
            RESTORE:  state_n = RST_HOLD;
            RST_HOLD: if (cnt == CW'(RST_DLY - 1)) state_n = ISO_OFF;
            ISO_OFF:  state_n = ON;
            default:  state_n = OFF;
        endcase
        cnt_n        = (state_n == state) ? cnt + CW'(1) : '0;
        pwr_on_nx    = !(state_n inside {OFF, PSW_OFF});
        clk_en_nx    = state_n == ON;
        iso_en_nx    = !(state_n inside {ON, CG_OFF, ISO_OFF});
        save_nx      = state_n == SAVE;
        restore_nx   = state_n == RESTORE;
        dom_rst_n_nx = !(state_n inside {OFF, PSW_ON, RESTORE, RST_HOLD});
        busy_nx      = !(state_n inside {ON, OFF});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= OFF;
            cnt         <= '0;
            ret_valid   <= 1'b0;
            err_timeout <= 1'b0;
            pwr_on      <= 1'b0;
            clk_en      <= 1'b0;
            iso_en      <= 1'b1;
            save        <= 1'b0;
            restore     <= 1'b0;
            dom_rst_n   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            ret_valid   <= ret_n;
            err_timeout <= err_n;
            pwr_on      <= pwr_on_nx;
            clk_en      <= clk_en_nx;
            iso_en      <= iso_en_nx;
            save        <= save_nx;
            restore     <= restore_nx;
            dom_rst_n   <= dom_rst_n_nx;
            busy        <= busy_nx;
        end
    end

    assign state_o = state;
endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// tb_pwr_seq_ctrl: table-driven and hand-sequenced checks of pwr_seq_ctrl with a per-cycle expected-output scoreboard
module tb_pwr_seq_ctrl;
    localparam int TMO = 8;

    // {pwr_on, clk_en, iso_en, save, restore, dom_rst_n, busy}
    localparam logic [6:0] S_OFF = 7'b0010000;
    localparam logic [6:0] S_PON = 7'b1010001;
    localparam logic [6:0] S_RES = 7'b1010101;
    localparam logic [6:0] S_RH  = 7'b1010001;
    localparam logic [6:0] S_IOF = 7'b1000011;
    localparam logic [6:0] S_ON  = 7'b1100010;
    localparam logic [6:0] S_CG  = 7'b1000011;
    localparam logic [6:0] S_ISO = 7'b1010011;
    localparam logic [6:0] S_SAV = 7'b1011011;
    localparam logic [6:0] S_POF = 7'b0010011;

    typedef struct {
        logic       rn, pd, pu, ack;
        logic [6:0] o;
        logic       err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0, pd_req = 1'b0, pu_req = 1'b0, pwr_ack = 1'b0;
    logic       pwr_on, clk_en, iso_en, save, restore, dom_rst_n, busy, err_timeout;
    logic [3:0] state_o;
    logic [7:0] sb[$];
    vec_t       tbl[$];
    int         checks = 0, errors = 0;

    pwr_seq_ctrl #(.ISO_DLY(2), .RST_DLY(2), .SW_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .pd_req(pd_req), .pu_req(pu_req), .pwr_ack(pwr_ack),
        .pwr_on(pwr_on), .clk_en(clk_en), .iso_en(iso_en), .save(save), .restore(restore),
        .dom_rst_n(dom_rst_n), .busy(busy), .err_timeout(err_timeout), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(logic rn, logic pd, logic pu, logic ack, logic [6:0] o, logic err);
        vec_t r;
        r.rn = rn; r.pd = pd; r.pu = pu; r.ack = ack; r.o = o; r.err = err;
        return r;
    endfunction

    task automatic cyc(input string tag, input logic rn, input logic pd, input logic pu,
                       input logic ack, input logic [6:0] o, input logic err);
        logic [7:0] exp, act;
        @(negedge clk);
        rst_n   = rn;
        pd_req  = pd;
        pu_req  = pu;
        pwr_ack = ack;
        sb.push_back({o, err});
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        act = {pwr_on, clk_en, iso_en, save, restore, dom_rst_n, busy, err_timeout};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b want %b (pwr_on,clk_en,iso_en,save,restore,dom_rst_n,busy,err)",
                     tag, $time, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl.push_back(v(0,0,0,0,S_OFF,0));
        tbl.push_back(v(1,0,0,0,S_OFF,0));
        tbl.push_back(v(1,0,1,0,S_PON,0));
        tbl.push_back(v(1,0,0,0,S_PON,0));
        tbl.push_back(v(1,0,0,1,S_RH ,0));
        tbl.push_back(v(1,0,0,1,S_RH ,0));
        tbl.push_back(v(1,0,0,1,S_IOF,0));
        tbl.push_back(v(1,0,0,1,S_ON ,0));
        tbl.push_back(v(1,0,0,1,S_ON ,0));
        tbl.push_back(v(1,1,0,1,S_CG ,0));
        tbl.push_back(v(1,0,0,1,S_ISO,0));
        tbl.push_back(v(1,0,0,1,S_ISO,0));
        tbl.push_back(v(1,0,0,1,S_SAV,0));
        tbl.push_back(v(1,0,0,1,S_POF,0));
        tbl.push_back(v(1,0,0,1,S_POF,0));
        tbl.push_back(v(1,0,0,0,S_OFF,0));
        tbl.push_back(v(1,0,1,0,S_PON,0));
        tbl.push_back(v(1,0,0,0,S_PON,0));
        tbl.push_back(v(1,0,0,1,S_RES,0));
        tbl.push_back(v(1,0,0,1,S_RH ,0));
        tbl.push_back(v(1,0,0,1,S_RH ,0));
        tbl.push_back(v(1,0,0,1,S_IOF,0));
        tbl.push_back(v(1,0,0,1,S_ON ,0));
        tbl.push_back(v(1,1,1,1,S_CG ,0));
        tbl.push_back(v(1,1,1,1,S_ISO,0));
        tbl.push_back(v(1,1,1,1,S_ISO,0));
        tbl.push_back(v(1,1,1,1,S_SAV,0));
        tbl.push_back(v(1,1,1,1,S_POF,0));
        tbl.push_back(v(1,1,1,0,S_OFF,0));
        tbl.push_back(v(1,1,1,0,S_PON,0));
        tbl.push_back(v(1,0,0,0,S_PON,0));
        tbl.push_back(v(1,0,0,1,S_RES,0));
        tbl.push_back(v(1,0,0,1,S_RH ,0));
        tbl.push_back(v(1,0,0,1,S_RH ,0));
        tbl.push_back(v(1,0,0,1,S_IOF,0));
        tbl.push_back(v(1,0,0,1,S_ON ,0));

        foreach (tbl[i]) cyc($sformatf("tbl[%0d]", i), tbl[i].rn, tbl[i].pd, tbl[i].pu, tbl[i].ack, tbl[i].o, tbl[i].err);

        // power-down, then power-up where ack arrives on the last permitted wait cycle
        cyc("ackwin_cg", 1,1,0,1,S_CG ,0);
        cyc("ackwin_iso", 1,0,0,1,S_ISO,0);
        cyc("ackwin_iso", 1,0,0,1,S_ISO,0);
        cyc("ackwin_sav", 1,0,0,1,S_SAV,0);
        cyc("ackwin_pof", 1,0,0,1,S_POF,0);
        cyc("ackwin_off", 1,0,0,0,S_OFF,0);
        cyc("ackwin_pon", 1,0,1,0,S_PON,0);
        for (int i = 0; i < TMO - 1; i++) cyc("ackwin_wait", 1,0,0,0,S_PON,0);
        cyc("ackwin_res", 1,0,0,1,S_RES,0);
        cyc("ackwin_rh", 1,0,0,1,S_RH ,0);
        cyc("ackwin_rh", 1,0,0,1,S_RH ,0);
        cyc("ackwin_iof", 1,0,0,1,S_IOF,0);
        cyc("ackwin_on", 1,0,0,1,S_ON ,0);

        // pwr_ack stuck high during power-down
        cyc("pdto_cg", 1,1,0,1,S_CG ,0);
        cyc("pdto_iso", 1,0,0,1,S_ISO,0);
        cyc("pdto_iso", 1,0,0,1,S_ISO,0);
        cyc("pdto_sav", 1,0,0,1,S_SAV,0);
        cyc("pdto_pof", 1,0,0,1,S_POF,0);
        for (int i = 0; i < TMO - 1; i++) cyc("pdto_wait", 1,0,0,1,S_POF,0);
        cyc("pdto_off", 1,0,0,1,S_OFF,1);
        cyc("pdto_off2", 1,0,0,0,S_OFF,1);

        // power-up with no ack: timeout back to OFF, retention kept
        cyc("puto_pon", 1,0,1,0,S_PON,1);
        for (int i = 0; i < TMO - 1; i++) cyc("puto_wait", 1,0,0,0,S_PON,1);
        cyc("puto_off", 1,0,0,0,S_OFF,1);
        cyc("puto_off2", 1,0,0,0,S_OFF,1);

        // good power-up afterwards: restore still issued, error stays sticky
        cyc("retry_pon", 1,0,1,0,S_PON,1);
        cyc("retry_res", 1,0,0,1,S_RES,1);
        cyc("retry_rh", 1,0,0,1,S_RH ,1);
        cyc("retry_rh", 1,0,0,1,S_RH ,1);
        cyc("retry_iof", 1,0,0,1,S_IOF,1);
        cyc("retry_on", 1,0,0,1,S_ON ,1);

        // reset while in ISO_ON clears everything, next power-up is cold
        cyc("rst_cg", 1,1,0,1,S_CG ,1);
        cyc("rst_iso", 1,0,0,1,S_ISO,1);
        cyc("rst_abort", 0,0,0,1,S_OFF,0);
        cyc("rst_idle", 1,0,0,0,S_OFF,0);
        cyc("cold_pon", 1,0,1,0,S_PON,0);
        cyc("cold_rh", 1,0,0,1,S_RH ,0);
        cyc("cold_rh", 1,0,0,1,S_RH ,0);
        cyc("cold_iof", 1,0,0,1,S_IOF,0);
        cyc("cold_on", 1,0,0,1,S_ON ,0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwr_seq_ctrl.md
Name: pwr_seq_ctrl

Overview:
Power-sequencing controller for one switchable domain. It sits directly upstream of the domain's logic and drives that domain's pwr_on input. It also drives the domain's clock enable, isolation, retention save/restore and domain reset, in the order the UPF power-down and power-up sequences require. Handshake with the power switch is via pwr_ack, with timeout detection.

Parameters:
ISO_DLY, 2, cycles iso_en is held asserted before the retention save (min 1)
RST_DLY, 2, cycles dom_rst_n is held low after power-up/restore before release (min 1)
SW_TIMEOUT, 16, max cycles to wait for pwr_ack in either switch-wait state (min 2)

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
pd_req  in  1  power-down request (level); honoured only in ON
pu_req  in  1  power-up request (level); honoured only in OFF
pwr_ack  in  1  power-switch status; 1 = domain rail up
pwr_on  out  1  power-switch enable to domain
clk_en  out  1  domain clock-gate enable
iso_en  out  1  isolation clamp enable
save  out  1  retention save strobe, 1 cycle
restore  out  1  retention restore strobe, 1 cycle
dom_rst_n  out  1  domain reset, active-low
busy  out  1  1 in any state other than ON/OFF
err_timeout  out  1  sticky switch-ack timeout flag
state_o  out  4  current state encoding (debug/coverage)

Behaviour:
- All outputs registered, decoded from state; all state changes occur on posedge clk.
- Reset (rst_n=0 at a clock edge):
  - state=OFF; pwr_on=0, clk_en=0, iso_en=1, save=0, restore=0, dom_rst_n=0, busy=0, err_timeout=0; ret_valid=0; counters cleared.
  - Reset mid-sequence aborts immediately to OFF with these values.
- States and outputs (pwr_on, clk_en, iso_en, dom_rst_n):
  - ON: 1,1,0,1
  - CG_OFF: 1,0,0,1 (1 cycle)
  - ISO_ON: 1,0,1,1 (ISO_DLY cycles)
  - SAVE: 1,0,1,1, save=1 (1 cycle); sets ret_valid
  - PSW_OFF: 0,0,1,1 (wait pwr_ack==0)
  - OFF: 0,0,1,0
  - PSW_ON: 1,0,1,0 (wait pwr_ack==1)
  - RESTORE: 1,0,1,0, restore=1 (1 cycle); only entered if ret_valid
  - RST_HOLD: 1,0,1,0 (RST_DLY cycles)
  - ISO_OFF: 1,0,0,1 (1 cycle)
- Transitions:
  - ON -> CG_OFF when pd_req=1.
  - CG_OFF -> ISO_ON -> SAVE -> PSW_OFF.
  - PSW_OFF -> OFF when pwr_ack=0 is sampled.
  - OFF -> PSW_ON when pu_req=1.
  - PSW_ON -> RESTORE when pwr_ack=1 and ret_valid=1; otherwise PSW_ON -> RST_HOLD when pwr_ack=1.
  - RESTORE -> RST_HOLD -> ISO_OFF -> ON.
- Requests:
  - Sequences are not abortable by requests.
  - pd_req/pu_req are ignored outside ON/OFF respectively.
  - Both high simultaneously: only the one valid in the current state acts.
  - A request held high re-triggers on return to ON/OFF.
- Wait counter:
  - Cleared on entry to PSW_OFF/PSW_ON; increments each cycle while waiting.
  - Timeout when the count reaches SW_TIMEOUT with no ack: err_timeout set (sticky until rst_n).
  - PSW_OFF timeout -> OFF.
  - PSW_ON timeout -> OFF (pwr_on returns to 0); ret_valid is kept.
- ret_valid: cleared only by reset. Cold power-up (never saved) skips RESTORE.
- An ack arriving in the same cycle the count reaches SW_TIMEOUT wins: no error.
- Latency: pd_req sampled at edge k -> clk_en=0 after k, iso_en=1 after k+1, save after k+1+ISO_DLY, pwr_on=0 after k+2+ISO_DLY.

Test Plan:
- Reset with pd_req=pu_req=0 -> OFF: pwr_on=0, iso_en=1, clk_en=0, dom_rst_n=0, busy=0, err_timeout=0.
- Cold power-up, ack = pwr_on delayed 1 cycle, defaults -> no restore pulse; dom_rst_n low 2 cycles in RST_HOLD, then iso_en=0, then clk_en=1, ON; clk_en rises strictly after iso_en falls.
- Power-down from ON (pd_req pulse), defaults -> clk_en=0 at k+1, iso_en=1 at k+2, save pulse at k+4 (1 cycle), pwr_on=0 at k+5, OFF after pwr_ack falls; a following power-up emits exactly one restore pulse.
- pwr_ack stuck at 1 during power-down, SW_TIMEOUT=8 -> OFF after 8 cycles in PSW_OFF, err_timeout=1 and stays 1 through later good sequences until rst_n.
- pd_req and pu_req both high in ON -> power-down only; pu_req still high on reaching OFF -> immediate power-up.
- rst_n asserted while in ISO_ON -> next cycle OFF with all reset values; ret_valid=0, so the next power-up skips RESTORE.
